// File: rtl/car_alarm_pkg.sv
// Shared definitions for the car alarm controller: state encodings, door limit
// and the helper that sizes the shared countdown timer.
package car_alarm_pkg;

  localparam int MaxDoors = 16;

  typedef enum logic [2:0] {
    StDisarmed = 3'd0,
    StArming   = 3'd1,
    StArmed    = 3'd2,
    StEntry    = 3'd3,
    StAlarm    = 3'd4
  } alarmState_e;

  // Bits needed to hold the largest of the three delays without wrapping.
  function automatic int counterWidth(input int armDelay, input int entryDelay,
                                      input int sirenTime);
    int maxDelay;
    maxDelay = armDelay;
    if (entryDelay > maxDelay) maxDelay = entryDelay;
    if (sirenTime > maxDelay) maxDelay = sirenTime;
    return $clog2(maxDelay + 1);
  endfunction

endpackage

// File: rtl/car_alarm_ctrl_timer.sv
// Saturating down-counter shared by the ARMING, ENTRY and ALARM phases.
// expire is high during the last cycle of a loaded period.
module alarm_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A period of N cycles starts at N, so the final cycle is the one at 1.
  assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/car_alarm_ctrl.sv
// Car alarm controller: passive arming after an exit, entry-delay chime,
// bounded siren and per-door re-trigger masking, plus the lights-on warning.
module car_alarm_ctrl
  import car_alarm_pkg::*;
#(
  parameter int NUM_DOORS   = 4,
  parameter int ARM_DELAY   = 16,
  parameter int ENTRY_DELAY = 8,
  parameter int SIREN_TIME  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IgnitionSignalOn,
  input  logic                 CarLightsOnSign,
  input  logic [NUM_DOORS-1:0] OpenDoorSign,
  output logic                 PassiveSignal,
  output logic                 ArmedStatus,
  output logic                 EntryWarn,
  output logic                 SirenOn,
  output logic [2:0]           StateOut
);

  localparam logic [2:0] DISARMED = StDisarmed;
  localparam logic [2:0] ARMING   = StArming;
  localparam logic [2:0] ARMED    = StArmed;
  localparam logic [2:0] ENTRY    = StEntry;
  localparam logic [2:0] ALARM    = StAlarm;

  localparam int TimerWidth = counterWidth(ARM_DELAY, ENTRY_DELAY, SIREN_TIME);
  localparam logic [TimerWidth-1:0] ArmLoad   = TimerWidth'(ARM_DELAY);
  localparam logic [TimerWidth-1:0] EntryLoad = TimerWidth'(ENTRY_DELAY);
  localparam logic [TimerWidth-1:0] SirenLoad = TimerWidth'(SIREN_TIME);

  logic [2:0]            state;
  logic [2:0]            nextState;
  logic                  exitSeen;
  logic [NUM_DOORS-1:0]  doorMask;
  logic [NUM_DOORS-1:0]  effDoor;
  logic                  anyDoor;
  logic                  timerLoad;
  logic [TimerWidth-1:0] timerLoadValue;
  logic                  timerExpire;

  assign anyDoor = |OpenDoorSign;
  assign effDoor = OpenDoorSign & ~doorMask;

  alarm_timer #(
    .WIDTH(TimerWidth)
  ) uTimer (
    .clk       (clk),
    .reset     (reset),
    .load      (timerLoad),
    .load_value(timerLoadValue),
    .expire    (timerExpire)
  );

  // Ignition is the disarm key and beats everything; a door opening in ARMING
  // wins over timer expiry because the door test comes first.
  always_comb begin
    nextState      = state;
    timerLoad      = 1'b0;
    timerLoadValue = '0;
    if (IgnitionSignalOn) begin
      nextState = DISARMED;
    end else begin
      case (state)
        DISARMED: begin
          if (exitSeen && !anyDoor) begin
            nextState      = ARMING;
            timerLoad      = 1'b1;
            timerLoadValue = ArmLoad;
          end
        end
        ARMING: begin
          if (anyDoor) nextState = DISARMED;
          else if (timerExpire) nextState = ARMED;
        end
        ARMED: begin
          if (|effDoor) begin
            nextState      = ENTRY;
            timerLoad      = 1'b1;
            timerLoadValue = EntryLoad;
          end
        end
        ENTRY: begin
          if (timerExpire) begin
            nextState      = ALARM;
            timerLoad      = 1'b1;
            timerLoadValue = SirenLoad;
          end
        end
        ALARM: begin
          if (timerExpire) nextState = ARMED;
        end
        default: nextState = DISARMED;
      endcase
    end
  end

  // Doors still open when the siren stops are masked until they close once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= DISARMED;
      exitSeen      <= 1'b0;
      doorMask      <= '0;
      PassiveSignal <= 1'b0;
    end else begin
      state <= nextState;
      if (IgnitionSignalOn) exitSeen <= 1'b0;
      else if (state == DISARMED && anyDoor) exitSeen <= 1'b1;
      if (nextState == DISARMED) doorMask <= '0;
      else if (state == ALARM && timerExpire) doorMask <= OpenDoorSign;
      else doorMask <= doorMask & OpenDoorSign;
      PassiveSignal <= CarLightsOnSign & anyDoor & ~IgnitionSignalOn;
    end
  end

  assign StateOut    = state;
  assign ArmedStatus = (state == ARMED) || (state == ENTRY) || (state == ALARM);
  assign EntryWarn   = (state == ENTRY);
  assign SirenOn     = (state == ALARM);

endmodule

// File: tb/tb_car_alarm_ctrl.sv
// Bench for car_alarm_ctrl: directed scenarios with literal expectations, then
// random traffic compared every cycle against a cycles-in-state reference model.
module tb_car_alarm_ctrl;

  localparam int ArmDelay   = 16;
  localparam int EntryDelay = 8;
  localparam int SirenTime  = 32;
  localparam int SDisarmed  = 0;
  localparam int SArming    = 1;
  localparam int SArmed     = 2;
  localparam int SEntry     = 3;
  localparam int SAlarm     = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ignition;
  logic       lights;
  logic [3:0] doors;
  logic       PassiveSignal;
  logic       ArmedStatus;
  logic       EntryWarn;
  logic       SirenOn;
  logic [2:0] StateOut;

  int checks   = 0;
  int failures = 0;

  car_alarm_ctrl #(
    .NUM_DOORS  (4),
    .ARM_DELAY  (ArmDelay),
    .ENTRY_DELAY(EntryDelay),
    .SIREN_TIME (SirenTime)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .IgnitionSignalOn(ignition),
    .CarLightsOnSign (lights),
    .OpenDoorSign    (doors),
    .PassiveSignal   (PassiveSignal),
    .ArmedStatus     (ArmedStatus),
    .EntryWarn       (EntryWarn),
    .SirenOn         (SirenOn),
    .StateOut        (StateOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Hold the given inputs for one clock period and return just after the edge.
  task automatic applyStimulus(input logic ign, input logic lit, input logic [3:0] drs);
    ignition = ign;
    lights   = lit;
    doors    = drs;
    @(posedge clk);
    #2;
  endtask

  // Reference model: tracks how many cycles have been spent in the current state
  // and compares that count directly against the configured delays.
  int   mState     = SDisarmed;
  int   mCycles    = 1;
  bit   mExit      = 1'b0;
  bit   mMask[4]   = '{default: 1'b0};
  bit   mPassive   = 1'b0;
  bit   modelValid = 1'b0;

  always @(posedge clk) begin
    int  ns;
    bit  anyOpen;
    bit  effOpen;
    if (reset) begin
      mState     = SDisarmed;
      mCycles    = 1;
      mExit      = 1'b0;
      mMask      = '{default: 1'b0};
      mPassive   = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      anyOpen = (doors != 4'b0);
      effOpen = 1'b0;
      for (int d = 0; d < 4; d++) if (doors[d] && !mMask[d]) effOpen = 1'b1;
      ns = mState;
      if (ignition) ns = SDisarmed;
      else begin
        case (mState)
          SDisarmed: if (mExit && !anyOpen) ns = SArming;
          SArming:   ns = anyOpen ? SDisarmed : (mCycles == ArmDelay ? SArmed : SArming);
          SArmed:    if (effOpen) ns = SEntry;
          SEntry:    if (mCycles == EntryDelay) ns = SAlarm;
          SAlarm:    if (mCycles == SirenTime) ns = SArmed;
          default:   ns = SDisarmed;
        endcase
      end
      for (int d = 0; d < 4; d++) begin
        if (ns == SDisarmed) mMask[d] = 1'b0;
        else if (mState == SAlarm && ns == SArmed) mMask[d] = doors[d];
        else if (!doors[d]) mMask[d] = 1'b0;
      end
      if (ignition) mExit = 1'b0;
      else if (mState == SDisarmed && anyOpen) mExit = 1'b1;
      mPassive = lights && anyOpen && !ignition;
      mCycles  = (ns != mState) ? 1 : ((mCycles < 100000) ? mCycles + 1 : mCycles);
      mState   = ns;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model StateOut", int'(StateOut), mState);
      checkOutput("model ArmedStatus", int'(ArmedStatus), int'(mState >= SArmed));
      checkOutput("model EntryWarn", int'(EntryWarn), int'(mState == SEntry));
      checkOutput("model SirenOn", int'(SirenOn), int'(mState == SAlarm));
      checkOutput("model PassiveSignal", int'(PassiveSignal), int'(mPassive));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Exit via door0 held open three cycles, then count the ARMING residency.
  task automatic armVehicle(output int armLen);
    int n;
    applyStimulus(1'b1, 1'b0, 4'b0000);
    repeat (3) applyStimulus(1'b0, 1'b0, 4'b0001);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    n = 0;
    while (StateOut == 3'd1 && n < 40) begin
      n++;
      applyStimulus(1'b0, 1'b0, 4'b0000);
    end
    armLen = n;
  endtask

  initial begin
    int  n;
    int  ewCount;
    bit  sirenSeen;
    bit  retrig;
    reset    = 1'b1;
    ignition = 1'b0;
    lights   = 1'b0;
    doors    = 4'b0000;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset StateOut", int'(StateOut), 0);
    checkOutput("reset ArmedStatus", int'(ArmedStatus), 0);
    checkOutput("reset SirenOn", int'(SirenOn), 0);
    checkOutput("reset PassiveSignal", int'(PassiveSignal), 0);
    reset = 1'b0;

    armVehicle(n);
    checkOutput("arming length", n, 16);
    checkOutput("armed StateOut", int'(StateOut), 2);
    checkOutput("armed ArmedStatus", int'(ArmedStatus), 1);

    applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0100);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    repeat (15) applyStimulus(1'b0, 1'b0, 4'b0000);
    checkOutput("arming cycle16 state", int'(StateOut), 1);
    applyStimulus(1'b0, 1'b0, 4'b0100);
    checkOutput("abort at expiry", int'(StateOut), 0);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    n = 0;
    while (StateOut == 3'd1 && n < 40) begin
      n++;
      applyStimulus(1'b0, 1'b0, 4'b0000);
    end
    checkOutput("rearm length", n, 16);
    checkOutput("rearmed StateOut", int'(StateOut), 2);

    ewCount   = 0;
    sirenSeen = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'b0010);
    if (EntryWarn) ewCount++;
    if (SirenOn) sirenSeen = 1'b1;
    repeat (4) begin
      applyStimulus(1'b0, 1'b0, 4'b0010);
      if (EntryWarn) ewCount++;
      if (SirenOn) sirenSeen = 1'b1;
    end
    applyStimulus(1'b1, 1'b0, 4'b0010);
    if (EntryWarn) ewCount++;
    if (SirenOn) sirenSeen = 1'b1;
    checkOutput("entry warn cycles", ewCount, 5);
    checkOutput("entry disarm state", int'(StateOut), 0);
    checkOutput("entry siren never", int'(sirenSeen), 0);

    armVehicle(n);
    applyStimulus(1'b0, 1'b0, 4'b1000);
    n = 0;
    while (StateOut == 3'd3 && n < 40) begin
      n++;
      applyStimulus(1'b0, 1'b0, 4'b1000);
    end
    checkOutput("entry length", n, 8);
    n = 0;
    while (SirenOn && n < 80) begin
      n++;
      applyStimulus(1'b0, 1'b0, 4'b1000);
    end
    checkOutput("siren length", n, 32);
    checkOutput("post alarm state", int'(StateOut), 2);
    retrig = 1'b0;
    repeat (5) begin
      applyStimulus(1'b0, 1'b0, 4'b1000);
      if (StateOut != 3'd2) retrig = 1'b1;
    end
    checkOutput("masked door no retrigger", int'(retrig), 0);
    applyStimulus(1'b0, 1'b0, 4'b1001);
    checkOutput("new door retrigger", int'(StateOut), 3);

    n = 0;
    while (StateOut == 3'd3 && n < 40) begin
      n++;
      applyStimulus(1'b0, 1'b0, 4'b1001);
    end
    repeat (9) applyStimulus(1'b0, 1'b0, 4'b1001);
    checkOutput("alarm cycle10 siren", int'(SirenOn), 1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b1001);
    checkOutput("reset mid alarm StateOut", int'(StateOut), 0);
    checkOutput("reset mid alarm SirenOn", int'(SirenOn), 0);
    checkOutput("reset mid alarm ArmedStatus", int'(ArmedStatus), 0);
    checkOutput("reset mid alarm EntryWarn", int'(EntryWarn), 0);
    reset = 1'b0;

    applyStimulus(1'b0, 1'b1, 4'b0001);
    checkOutput("passive set", int'(PassiveSignal), 1);
    applyStimulus(1'b1, 1'b1, 4'b0001);
    checkOutput("passive cleared by ignition", int'(PassiveSignal), 0);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] newDoors;
      reset = ($urandom_range(0, 499) == 0);
      newDoors = doors;
      if ($urandom_range(0, 9) == 0)
        newDoors = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      applyStimulus(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), newDoors);
    end
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
